// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// fft_pkg : shared FSM encoding and default sizing for the FFT peak detector
// Rev 1.0
// ============================================================================
package fft_pkg;

  localparam int c_DEFAULT_N_POINTS = 64;
  localparam int c_DEFAULT_DATA_W   = 16;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fft_peak_detector_if.sv
`default_nettype none
// ============================================================================
// fft_peak_detector_if : FFT bin input stream and peak result handshake
// Rev 1.0
// ============================================================================
interface fft_peak_detector_if
  import fft_pkg::*;
#(
  parameter int N_POINTS = c_DEFAULT_N_POINTS,
  parameter int DATA_W   = c_DEFAULT_DATA_W
);
  localparam int c_BIN_W = $clog2(N_POINTS);

  logic                  i_data_valid;
  logic [2*DATA_W-1:0]   i_data;
  logic                  o_data_ready;
  logic                  o_peak_valid;
  logic [c_BIN_W-1:0]    o_peak_bin;
  logic [2*DATA_W-1:0]   o_peak_mag;
  logic                  i_peak_ready;
  logic [15:0]           o_frame_cnt;

  modport master (
    output i_data_valid, i_data, i_peak_ready,
    input  o_data_ready, o_peak_valid, o_peak_bin, o_peak_mag, o_frame_cnt
  );

  modport slave (
    input  i_data_valid, i_data, i_peak_ready,
    output o_data_ready, o_peak_valid, o_peak_bin, o_peak_mag, o_frame_cnt
  );

endinterface
`default_nettype wire

// File: rtl/fft_peak_detector_mag_sq.sv
`default_nettype none
// ============================================================================
// fft_mag_sq : two-stage re^2 + im^2 pipeline (registered squares, then sum)
// Rev 1.0
// ============================================================================
module fft_mag_sq
  import fft_pkg::*;
#(
  parameter int DATA_W = c_DEFAULT_DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [DATA_W-1:0]   i_re,
  input  logic [DATA_W-1:0]   i_im,
  output logic                o_valid,
  output logic [2*DATA_W-1:0] o_mag
);

  logic signed [2*DATA_W-1:0] w_re_ext;
  logic signed [2*DATA_W-1:0] w_im_ext;
  logic [2*DATA_W-1:0]        r_re_sq;
  logic [2*DATA_W-1:0]        r_im_sq;
  logic                       r_s1_valid;
  logic                       r_s2_valid;
  logic [2*DATA_W-1:0]        r_mag;

  // Each square is at most 2^(2*DATA_W-2), so the sum never exceeds 2*DATA_W bits.
  assign w_re_ext = {{DATA_W{i_re[DATA_W-1]}}, i_re};
  assign w_im_ext = {{DATA_W{i_im[DATA_W-1]}}, i_im};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_re_sq    <= '0;
      r_im_sq    <= '0;
      r_mag      <= '0;
    end else begin
      r_s1_valid <= i_valid;
      r_s2_valid <= r_s1_valid;
      if (i_valid) begin
        r_re_sq <= w_re_ext * w_re_ext;
        r_im_sq <= w_im_ext * w_im_ext;
      end
      if (r_s1_valid) begin
        r_mag <= r_re_sq + r_im_sq;
      end
    end
  end

  assign o_valid = r_s2_valid;
  assign o_mag   = r_mag;

endmodule
`default_nettype wire

// File: rtl/fft_peak_detector.sv
`default_nettype none
// ============================================================================
// fft_peak_detector : per-frame peak-magnitude bin search over FFT output
// Rev 1.0
// ============================================================================
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter int N_POINTS = c_DEFAULT_N_POINTS,
  parameter int DATA_W   = c_DEFAULT_DATA_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  fft_peak_detector_if.slave bus
);

  localparam int                 c_BIN_W    = $clog2(N_POINTS);
  localparam logic [c_BIN_W-1:0] c_LAST_BIN = c_BIN_W'(N_POINTS - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic                 w_peak_load;
  logic                 w_frame_done;
  logic                 r_ready;
  logic [c_BIN_W-1:0]   r_bin_cnt;
  logic [c_BIN_W-1:0]   r_bin_d1;
  logic [c_BIN_W-1:0]   r_bin_d2;
  logic [1:0]           r_drain_cnt;
  logic                 w_mag_valid;
  logic [2*DATA_W-1:0]  w_mag;
  logic [2*DATA_W-1:0]  r_max;
  logic [c_BIN_W-1:0]   r_max_bin;
  logic [2*DATA_W-1:0]  r_peak_mag;
  logic [c_BIN_W-1:0]   r_peak_bin;
  logic [15:0]          r_frame_cnt;

  assign w_accept = bus.i_data_valid && r_ready;

  fft_mag_sq #(
    .DATA_W (DATA_W)
  ) u_mag_sq (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_accept),
    .i_re    (bus.i_data[2*DATA_W-1:DATA_W]),
    .i_im    (bus.i_data[DATA_W-1:0]),
    .o_valid (w_mag_valid),
    .o_mag   (w_mag)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // DRAIN spans the two pipeline stages plus the final compare of the last bin.
  always_comb begin
    w_state_next = r_state;
    w_peak_load  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept && (r_bin_cnt == c_LAST_BIN)) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == 2'd2) begin
          w_state_next = ST_HOLD;
          w_peak_load  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.i_peak_ready) begin
          w_state_next = ST_ACCUM;
          w_frame_done = 1'b1;
        end
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ready     <= 1'b0;
      r_bin_cnt   <= '0;
      r_bin_d1    <= '0;
      r_bin_d2    <= '0;
      r_drain_cnt <= 2'd0;
      r_max       <= '0;
      r_max_bin   <= '0;
      r_peak_mag  <= '0;
      r_peak_bin  <= '0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_ready     <= (w_state_next == ST_ACCUM);
      r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
      r_bin_d1    <= r_bin_cnt;
      r_bin_d2    <= r_bin_d1;
      if (w_accept) begin
        r_bin_cnt <= r_bin_cnt + c_BIN_W'(1);
      end
      // Bin 0 restarts the search; afterwards only a strictly larger value wins.
      if (w_mag_valid && ((r_bin_d2 == '0) || (w_mag > r_max))) begin
        r_max     <= w_mag;
        r_max_bin <= r_bin_d2;
      end
      if (w_peak_load) begin
        r_peak_mag <= r_max;
        r_peak_bin <= r_max_bin;
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign bus.o_data_ready = r_ready;
  assign bus.o_peak_valid = (r_state == ST_HOLD);
  assign bus.o_peak_bin   = r_peak_bin;
  assign bus.o_peak_mag   = r_peak_mag;
  assign bus.o_frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_detector.sv
`default_nettype none
// ============================================================================
// tb_fft_peak_detector : directed table plus randomized frames for N_POINTS=8
// Rev 1.0
// ============================================================================
module tb_fft_peak_detector;
  import fft_pkg::*;

  localparam int c_N      = 8;
  localparam int c_W      = 16;
  localparam int c_N_VECS = 12;

  typedef struct {
    logic [c_N-1:0][31:0] data;
    bit                   gappy;
    int                   ready_wait;
    int                   exp_bin;
    logic [31:0]          exp_mag;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst;
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   exp_frames = 0;
  vec_t vecs[c_N_VECS];

  fft_peak_detector_if #(.N_POINTS(c_N), .DATA_W(c_W)) bus ();

  fft_peak_detector #(
    .N_POINTS (c_N),
    .DATA_W   (c_W)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: magnitude of every bin, overall maximum, then the first bin holding it.
  task automatic ref_peak(input logic [c_N-1:0][31:0] d, output int bin, output logic [31:0] mag);
    longint m[c_N];
    longint best;
    longint re;
    longint im;
    best = 0;
    for (int b = 0; b < c_N; b++) begin
      re   = longint'($signed(d[b][31:16]));
      im   = longint'($signed(d[b][15:0]));
      m[b] = re * re + im * im;
      if (m[b] > best) best = m[b];
    end
    bin = -1;
    for (int b = 0; b < c_N; b++) begin
      if (bin < 0 && m[b] == best) bin = b;
    end
    mag = 32'(best);
  endtask

  task automatic send_samples(input logic [c_N-1:0][31:0] d, input int count, input bit gappy);
    int guard;
    for (int b = 0; b < count; b++) begin
      if (gappy) begin
        @(negedge i_clk);
        bus.i_data_valid = 1'b0;
        bus.i_data       = $urandom;
      end
      @(negedge i_clk);
      bus.i_data_valid = 1'b1;
      bus.i_data       = d[b];
      guard = 0;
      while (!bus.o_data_ready && guard < 50) begin
        @(negedge i_clk);
        guard++;
      end
      if (guard >= 50) begin
        n_checks++;
        $display("FAIL accept_wait: o_data_ready low for %0d cycles, required high", guard);
      end
      @(posedge i_clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit stable;
    bus.i_peak_ready = (v.ready_wait == 0);
    send_samples(v.data, c_N, v.gappy);
    #1 bus.i_data_valid = 1'b0;
    lat = 0;
    while (bus.o_peak_valid !== 1'b1 && lat < 20) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'd3);
    check($sformatf("v%0d_bin", idx), 32'(bus.o_peak_bin), 32'(v.exp_bin));
    check($sformatf("v%0d_mag", idx), bus.o_peak_mag, v.exp_mag);
    check($sformatf("v%0d_ready_in_hold", idx), 32'(bus.o_data_ready), 32'd0);
    if (v.ready_wait > 0) begin
      stable = 1'b1;
      repeat (v.ready_wait) begin
        @(posedge i_clk);
        #1;
        if (bus.o_peak_valid !== 1'b1 || bus.o_peak_bin !== 3'(v.exp_bin) ||
            bus.o_peak_mag !== v.exp_mag || bus.o_data_ready !== 1'b0) stable = 1'b0;
      end
      check($sformatf("v%0d_hold_stable", idx), 32'(stable), 32'd1);
      bus.i_peak_ready = 1'b1;
    end
    @(posedge i_clk);
    #1;
    exp_frames++;
    check($sformatf("v%0d_valid_after_hs", idx), 32'(bus.o_peak_valid), 32'd0);
    check($sformatf("v%0d_frame_cnt", idx), 32'(bus.o_frame_cnt), 32'(exp_frames));
    check($sformatf("v%0d_ready_after_hs", idx), 32'(bus.o_data_ready), 32'd1);
    bus.i_peak_ready = 1'b0;
  endtask

  initial begin
    logic [c_N-1:0][31:0] d;
    logic [15:0]          re;
    logic [15:0]          im;
    vec_t                 v;

    bus.i_data_valid = 1'b0;
    bus.i_data       = '0;
    bus.i_peak_ready = 1'b0;
    i_rst            = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ready", 32'(bus.o_data_ready), 32'd0);
    check("rst_valid", 32'(bus.o_peak_valid), 32'd0);
    check("rst_bin", 32'(bus.o_peak_bin), 32'd0);
    check("rst_mag", bus.o_peak_mag, 32'd0);
    check("rst_frame_cnt", 32'(bus.o_frame_cnt), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check("ready_after_rst", 32'(bus.o_data_ready), 32'd1);

    for (int i = 0; i < c_N_VECS; i++) begin
      vecs[i].data       = '0;
      vecs[i].gappy      = 1'b0;
      vecs[i].ready_wait = 0;
      vecs[i].exp_bin    = 0;
      vecs[i].exp_mag    = 32'd0;
    end
    vecs[0].data[5]    = {16'd3, 16'd4};
    vecs[0].ready_wait = 10;
    vecs[0].exp_bin    = 5;
    vecs[0].exp_mag    = 32'd25;
    vecs[1].data[2]    = {16'd100, 16'd0};
    vecs[1].data[6]    = {16'd100, 16'd0};
    vecs[1].exp_bin    = 2;
    vecs[1].exp_mag    = 32'd10000;
    vecs[2].data[7]    = 32'h8000_8000;
    vecs[2].ready_wait = 2;
    vecs[2].exp_bin    = 7;
    vecs[2].exp_mag    = 32'h8000_0000;
    vecs[3]            = vecs[0];
    vecs[3].gappy      = 1'b1;
    vecs[3].ready_wait = 0;
    vecs[4].ready_wait = 1;
    vecs[5].data[0]    = {16'hFFFB, 16'd0};
    vecs[5].data[3]    = {16'd0, 16'd4};
    vecs[5].data[6]    = {16'd3, 16'hFFFC};
    vecs[5].gappy      = 1'b1;
    vecs[5].exp_bin    = 0;
    vecs[5].exp_mag    = 32'd25;
    for (int i = 6; i < c_N_VECS; i++) begin
      for (int b = 0; b < c_N; b++) begin
        if (i % 2 == 1) begin
          vecs[i].data[b] = $urandom;
        end else begin
          re = 16'($urandom_range(0, 6)) - 16'd3;
          im = 16'($urandom_range(0, 6)) - 16'd3;
          vecs[i].data[b] = {re, im};
        end
      end
      vecs[i].gappy      = 1'($urandom_range(0, 1));
      vecs[i].ready_wait = int'($urandom_range(0, 4));
      ref_peak(vecs[i].data, vecs[i].exp_bin, vecs[i].exp_mag);
    end

    for (int i = 0; i < c_N_VECS; i++) begin
      run_vec(vecs[i], i);
    end

    // Abort a frame after four bins; the large bin 0 must not leak into the next frame.
    d    = '0;
    d[0] = {16'd1000, 16'd0};
    bus.i_peak_ready = 1'b1;
    send_samples(d, 4, 1'b0);
    @(negedge i_clk);
    bus.i_data_valid = 1'b0;
    i_rst            = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.o_data_ready), 32'd0);
    check("midrst_frame_cnt", 32'(bus.o_frame_cnt), 32'd0);
    check("midrst_mag", bus.o_peak_mag, 32'd0);
    @(posedge i_clk);
    #1;
    check("midrst_ready_held", 32'(bus.o_data_ready), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check("midrst_ready_release", 32'(bus.o_data_ready), 32'd1);
    exp_frames   = 0;
    v.data       = '0;
    v.data[1]    = {16'd7, 16'd0};
    v.gappy      = 1'b0;
    v.ready_wait = 0;
    v.exp_bin    = 1;
    v.exp_mag    = 32'd49;
    run_vec(v, 99);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_peak_detector.md
FFT_PEAK_DETECTOR -- requirements
Module: fft_peak_detector

Interface
REQ-001 SHALL have parameter N_POINTS, default 64, meaning FFT frame length in bins (power of two, 8..1024).
REQ-002 SHALL have parameter DATA_W, default 16, meaning signed width of each real/imag component.
REQ-003 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_data_valid  input  1  upstream FFT output word valid.
REQ-006 SHALL have port i_data  input  2*DATA_W  FFT bin: [2*DATA_W-1:DATA_W] real, [DATA_W-1:0] imag, both two's complement.
REQ-007 SHALL have port o_data_ready  output  1  block accepts i_data this cycle; drives the FFT's i_data_ready.
REQ-008 SHALL have port o_peak_valid  output  1  peak result held and valid.
REQ-009 SHALL have port o_peak_bin  output  log2(N_POINTS)  index of the peak bin.
REQ-010 SHALL have port o_peak_mag  output  2*DATA_W  unsigned re^2+im^2 of the peak bin.
REQ-011 SHALL have port i_peak_ready  input  1  consumer accepts result.
REQ-012 SHALL have port o_frame_cnt  output  16  completed-frame count, wraps 65535->0.

Function
REQ-013 SHALL implement FSM states ACCUM, DRAIN, HOLD; reset state ACCUM.
REQ-014 SHALL assert o_data_ready only in ACCUM; a sample is accepted when i_data_valid && o_data_ready.
REQ-015 SHALL keep a bin counter, 0 at reset, incremented per accepted sample, wrapping N_POINTS-1 -> 0.
REQ-016 SHALL compute magnitude as re*re + im*im, unsigned 2*DATA_W bits, in a 2-stage pipeline (stage 1 registered squares, stage 2 registered sum) with no overflow; (-2^(DATA_W-1)) in both components SHALL give 2^(2*DATA_W-1).
REQ-017 SHALL compare each stage-2 magnitude with the running max; update max and bin index only on strictly greater, so ties keep the lowest bin.
REQ-018 SHALL treat bin 0 of each frame as unconditional load of max/index (no carry-over between frames).
REQ-019 SHALL transition ACCUM -> DRAIN on the cycle the sample with bin counter N_POINTS-1 is accepted.
REQ-020 SHALL stay in DRAIN until the last sample's stage-2 compare completes, then enter HOLD; o_peak_valid SHALL rise exactly 3 cycles after the last sample's accept edge.
REQ-021 SHALL hold o_peak_valid, o_peak_bin, o_peak_mag stable in HOLD until i_peak_ready is high at a clock edge, then return to ACCUM and deassert o_peak_valid on that edge.
REQ-022 SHALL increment o_frame_cnt on the HOLD -> ACCUM edge.
REQ-023 SHALL ignore i_data and i_data_valid while o_data_ready is low (no sample lost: upstream holds per handshake).
REQ-024 SHALL tolerate i_data_valid gaps in ACCUM; the pipeline advances only on accepted samples plus forced drain flush.
REQ-025 SHALL, when i_peak_ready is already high on HOLD entry, return to ACCUM after exactly one cycle of o_peak_valid.

Reset
REQ-026 SHALL on i_rst asynchronously set state ACCUM, bin counter 0, pipeline valids 0, max 0, o_peak_valid 0, o_peak_bin 0, o_peak_mag 0, o_frame_cnt 0, o_data_ready 0 while i_rst high.
REQ-027 SHALL on reset mid-frame discard the partial frame; first accepted sample after release is bin 0.
REQ-028 SHALL assert o_data_ready on the first clock edge after i_rst deasserts.

Structure
REQ-029 SHALL place FSM state enum, default N_POINTS and DATA_W constants in shared package fft_pkg.
REQ-030 SHALL implement the 2-stage magnitude pipeline as sub-module fft_mag_sq (in: valid, re, im; out: valid, mag).

Verification (N_POINTS=8, DATA_W=16)
REQ-031 Single peak: frame re=0,im=0 except bin 5 re=3,im=4 -> o_peak_bin=5, o_peak_mag=25, o_peak_valid 3 cycles after 8th accept.
REQ-032 Tie: bins 2 and 6 both re=100,im=0, rest 0 -> o_peak_bin=2, o_peak_mag=10000.
REQ-033 Extreme: bin 7 re=-32768,im=-32768 -> o_peak_mag=0x80000000, o_peak_bin=7.
REQ-034 Backpressure: i_peak_ready low 10 cycles -> o_data_ready low, outputs stable, next frame's bins start at 0 after handshake; o_frame_cnt=1.
REQ-035 Gappy input: i_data_valid toggled 1/0 across frame -> same result as gap-free frame.
REQ-036 Reset at bin 4 then full frame with peak at bin 1 (re=7) -> o_peak_bin=1, o_peak_mag=49, o_frame_cnt=1.
